ex_stage: RTL and testbench

Execute stage of the five-stage RV32I pipeline. It consumes the decoded operation latched by the ID/EX register and computes the ALU result, or the effective address for loads and stores. It registers the result toward the EX/MEM side. Shifts run on an area-saving one-bit-per-cycle serial shifter, so the stage stalls the upstream pipeline while a shift is in progress.

---
 rtl/rv_pkg.sv | 38 +++
 rtl/ex_stage_if.sv | 32 +++
 rtl/ex_stage_shifter.sv | 51 +++++
 rtl/ex_stage.sv | 164 ++++++++++++++++
 tb/tb_ex_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the execute-stage FSM state type.
// Also holds the small opcode/funct3 classification helpers used by ex_stage.
package rv_pkg;

    localparam logic [6:0] OPC_OP    = 7'h33;
    localparam logic [6:0] OPC_OPIMM = 7'h13;
    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ex_state_e;

    function automatic logic is_alu_op(input logic [6:0] t);
        return (t == OPC_OP) || (t == OPC_OPIMM);
    endfunction

    function automatic logic is_shift(input logic [6:0] t, input logic [2:0] f3);
        return is_alu_op(t) && ((f3 == F3_SLL) || (f3 == F3_SRL));
    endfunction

    // Anything outside this set travels down the pipe as a bubble.
    function automatic logic is_known_op(input logic [6:0] t);
        return is_alu_op(t) || (t == OPC_LUI) || (t == OPC_LOAD) || (t == OPC_STORE);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM pipeline bundle. The upstream pipeline owns the master side,
// the execute stage owns the slave side.
interface ex_stage_if #(parameter int XLEN = 32);

    logic            flush;
    logic [6:0]      ex_t;
    logic [2:0]      ex_st;
    logic            ex_sst;
    logic [XLEN-1:0] ex_n1;
    logic [XLEN-1:0] ex_n2;
    logic [4:0]      ex_wa;
    logic            ex_we;

    logic            stall_req;
    logic [6:0]      mem_t;
    logic [2:0]      mem_st;
    logic [XLEN-1:0] mem_res;
    logic [XLEN-1:0] mem_n2;
    logic [4:0]      mem_wa;
    logic            mem_we;

    modport master (
        output flush, ex_t, ex_st, ex_sst, ex_n1, ex_n2, ex_wa, ex_we,
        input  stall_req, mem_t, mem_st, mem_res, mem_n2, mem_wa, mem_we
    );

    modport slave (
        input  flush, ex_t, ex_st, ex_sst, ex_n1, ex_n2, ex_wa, ex_we,
        output stall_req, mem_t, mem_st, mem_res, mem_n2, mem_wa, mem_we
    );

endinterface

// File: rtl/ex_stage_shifter.sv
// One-bit-per-cycle shifter. start loads the operand and count; done is high
// in the cycle the count reaches 1, with o_result already holding the last step.
module serial_shifter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_data,
    input  logic [SHW-1:0]  i_amt,
    input  logic            i_left,
    input  logic            i_arith,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0] r_acc;
    logic [SHW-1:0]  r_cnt;
    logic            r_left;
    logic            r_arith;
    logic [XLEN-1:0] w_step;

    assign w_step   = r_left ? {r_acc[XLEN-2:0], 1'b0}
                             : {(r_arith & r_acc[XLEN-1]), r_acc[XLEN-1:1]};
    assign o_result = w_step;
    assign o_done   = (r_cnt == SHW'(1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc   <= i_data;
            r_cnt   <= i_amt;
            r_left  <= i_left;
            r_arith <= i_arith;
        end else if (r_cnt != '0) begin
            r_acc <= w_step;
            r_cnt <= r_cnt - SHW'(1);
        end
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: single-cycle ALU/address path plus a stalling serial
// shifter, with the EX/MEM output registers.
module ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);

    ex_state_e       r_state;
    ex_state_e       w_state_next;

    logic [6:0]      r_t;
    logic [2:0]      r_st;
    logic [4:0]      r_wa;
    logic            r_we;

    logic [6:0]      r_mem_t;
    logic [2:0]      r_mem_st;
    logic [XLEN-1:0] r_mem_res;
    logic [XLEN-1:0] r_mem_n2;
    logic [4:0]      r_mem_wa;
    logic            r_mem_we;

    logic [6:0]      w_nxt_t;
    logic [2:0]      w_nxt_st;
    logic [XLEN-1:0] w_nxt_res;
    logic [XLEN-1:0] w_nxt_n2;
    logic [4:0]      w_nxt_wa;
    logic            w_nxt_we;

    logic [XLEN-1:0] w_alu;
    logic [SHW-1:0]  w_shamt;
    logic            w_start;
    logic            w_stall;
    logic            w_sh_done;
    logic [XLEN-1:0] w_sh_result;

    assign w_shamt = bus.ex_n2[SHW-1:0];

    serial_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (bus.flush),
        .i_start  (w_start),
        .i_data   (bus.ex_n1),
        .i_amt    (w_shamt),
        .i_left   (bus.ex_st == F3_SLL),
        .i_arith  (bus.ex_sst),
        .o_done   (w_sh_done),
        .o_result (w_sh_result)
    );

    // Shift funct3 only reaches this path with shamt=0, so the result is n1 unchanged.
    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        w_alu = '0;
        if (is_alu_op(bus.ex_t)) begin
            unique case (bus.ex_st)
                F3_ADD:  w_alu = (bus.ex_t == OPC_OP && bus.ex_sst) ? bus.ex_n1 - bus.ex_n2
                                                                    : bus.ex_n1 + bus.ex_n2;
                F3_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.ex_n1) < $signed(bus.ex_n2))};
                F3_SLTU: w_alu = {{(XLEN-1){1'b0}}, (bus.ex_n1 < bus.ex_n2)};
                F3_XOR:  w_alu = bus.ex_n1 ^ bus.ex_n2;
                F3_OR:   w_alu = bus.ex_n1 | bus.ex_n2;
                F3_AND:  w_alu = bus.ex_n1 & bus.ex_n2;
                default: w_alu = bus.ex_n1;
            endcase
        end else if (bus.ex_t == OPC_LUI) begin
            w_alu = bus.ex_n2;
        end else if (bus.ex_t == OPC_LOAD || bus.ex_t == OPC_STORE) begin
            w_alu = bus.ex_n1 + bus.ex_n2;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_stall      = 1'b0;
        w_nxt_t      = '0;
        w_nxt_st     = '0;
        w_nxt_res    = '0;
        w_nxt_n2     = '0;
        w_nxt_wa     = '0;
        w_nxt_we     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.flush) begin
                    w_state_next = IDLE;
                end else if (is_shift(bus.ex_t, bus.ex_st) && w_shamt != '0) begin
                    w_start      = 1'b1;
                    w_stall      = 1'b1;
                    w_state_next = SHIFT;
                end else if (is_known_op(bus.ex_t)) begin
                    w_nxt_t   = bus.ex_t;
                    w_nxt_st  = bus.ex_st;
                    w_nxt_res = w_alu;
                    w_nxt_n2  = bus.ex_n2;
                    w_nxt_wa  = bus.ex_wa;
                    w_nxt_we  = bus.ex_we;
                end
            end
            SHIFT: begin
                if (bus.flush) begin
                    w_state_next = IDLE;
                end else if (w_sh_done) begin
                    w_state_next = IDLE;
                    w_nxt_t      = r_t;
                    w_nxt_st     = r_st;
                    w_nxt_res    = w_sh_result;
                    w_nxt_wa     = r_wa;
                    w_nxt_we     = r_we;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_t       <= '0;
            r_st      <= '0;
            r_wa      <= '0;
            r_we      <= 1'b0;
            r_mem_t   <= '0;
            r_mem_st  <= '0;
            r_mem_res <= '0;
            r_mem_n2  <= '0;
            r_mem_wa  <= '0;
            r_mem_we  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mem_t   <= w_nxt_t;
            r_mem_st  <= w_nxt_st;
            r_mem_res <= w_nxt_res;
            r_mem_n2  <= w_nxt_n2;
            r_mem_wa  <= w_nxt_wa;
            r_mem_we  <= w_nxt_we;
            if (w_start) begin
                r_t  <= bus.ex_t;
                r_st <= bus.ex_st;
                r_wa <= bus.ex_wa;
                r_we <= bus.ex_we;
            end
        end
    end

    // Held low during reset so a shift sitting in ID/EX cannot stall the pipe.
    assign bus.stall_req = rst_n & w_stall;
    assign bus.mem_t     = r_mem_t;
    assign bus.mem_st    = r_mem_st;
    assign bus.mem_res   = r_mem_res;
    assign bus.mem_n2    = r_mem_n2;
    assign bus.mem_wa    = r_mem_wa;
    assign bus.mem_we    = r_mem_we;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: hand-computed vectors driven and sampled on the
// falling edge, covering the ALU, serial shifts, reset and flush mid-shift.
module tb_ex_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ex_stage_if #(.XLEN(32)) bus ();

    ex_stage #(.XLEN(32), .SHW(5)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [6:0] t, input logic [2:0] st, input logic sst,
                         input logic [31:0] n1, input logic [31:0] n2,
                         input logic [4:0] wa, input logic we);
        bus.ex_t   = t;
        bus.ex_st  = st;
        bus.ex_sst = sst;
        bus.ex_n1  = n1;
        bus.ex_n2  = n2;
        bus.ex_wa  = wa;
        bus.ex_we  = we;
        #1;
    endtask

    task automatic bubble_in();
        drive(7'h00, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    // Single-cycle op: no stall, result after one edge.
    task automatic run_one(input string tag, input logic [6:0] t, input logic [2:0] st,
                           input logic sst, input logic [31:0] n1, input logic [31:0] n2,
                           input logic [31:0] exp_res);
        drive(t, st, sst, n1, n2, 5'd7, 1'b1);
        check({tag, "_stall"}, 32'(bus.stall_req), 32'd0);
        step();
        check({tag, "_res"}, bus.mem_res, exp_res);
    endtask

    // Shift with k>=1: stall for cycles 0..k-1, bubbles on edges 1..k, result after edge k+1.
    task automatic run_shift(input string tag, input logic [6:0] t, input logic [2:0] st,
                             input logic sst, input logic [31:0] n1, input logic [31:0] n2,
                             input int k, input logic [31:0] exp_res);
        drive(t, st, sst, n1, n2, 5'd9, 1'b1);
        for (int i = 0; i < k; i++) begin
            check({tag, "_stall_hi"}, 32'(bus.stall_req), 32'd1);
            step();
            check({tag, "_bubble_t"}, 32'(bus.mem_t), 32'd0);
            check({tag, "_bubble_we"}, 32'(bus.mem_we), 32'd0);
        end
        check({tag, "_stall_lo"}, 32'(bus.stall_req), 32'd0);
        step();
        check({tag, "_res"}, bus.mem_res, exp_res);
        check({tag, "_t"}, 32'(bus.mem_t), 32'(t));
        check({tag, "_wa"}, 32'(bus.mem_wa), 32'd9);
        check({tag, "_we"}, 32'(bus.mem_we), 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.flush = 1'b0;
        bubble_in();
        step();
        step();
        check("rst_res", bus.mem_res, 32'h0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_stall", 32'(bus.stall_req), 32'd0);
        rst_n = 1'b1;
        step();

        // ADD with full sideband check
        drive(7'h33, 3'b000, 1'b0, 32'd5, 32'd7, 5'd3, 1'b1);
        check("add_stall", 32'(bus.stall_req), 32'd0);
        step();
        check("add_res", bus.mem_res, 32'd12);
        check("add_wa", 32'(bus.mem_wa), 32'd3);
        check("add_we", 32'(bus.mem_we), 32'd1);
        check("add_t", 32'(bus.mem_t), 32'h33);

        run_one("sub", 7'h33, 3'b000, 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE);
        run_one("addi_sst", 7'h13, 3'b000, 1'b1, 32'd3, 32'd5, 32'd8);
        run_one("slt", 7'h33, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_one("sltu", 7'h33, 3'b011, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1);
        run_one("sltu_neg", 7'h13, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_one("xor", 7'h33, 3'b100, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
        run_one("or", 7'h13, 3'b110, 1'b0, 32'hA000_0001, 32'h0000_0F00, 32'hA000_0F01);
        run_one("and", 7'h33, 3'b111, 1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        run_one("lui", 7'h37, 3'b000, 1'b0, 32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000);
        run_one("sll_zero", 7'h33, 3'b001, 1'b0, 32'h1, 32'h20, 32'h1);

        // STORE: address plus store-data and size passthrough
        drive(7'h23, 3'b010, 1'b0, 32'h1000, 32'h20, 5'd0, 1'b0);
        step();
        check("st_res", bus.mem_res, 32'h1020);
        check("st_n2", bus.mem_n2, 32'h20);
        check("st_st", 32'(bus.mem_st), 32'd2);
        check("st_t", 32'(bus.mem_t), 32'h23);

        // Bubble and an unknown opcode both clear every output
        drive(7'h00, 3'b111, 1'b1, 32'h1234, 32'h5678, 5'd4, 1'b1);
        check("bub_stall", 32'(bus.stall_req), 32'd0);
        step();
        check("bub_res", bus.mem_res, 32'h0);
        check("bub_n2", bus.mem_n2, 32'h0);
        check("bub_wa", 32'(bus.mem_wa), 32'd0);
        check("bub_st", 32'(bus.mem_st), 32'd0);
        drive(7'h6F, 3'b000, 1'b0, 32'h1234, 32'h5678, 5'd4, 1'b1);
        step();
        check("unk_we", 32'(bus.mem_we), 32'd0);
        check("unk_t", 32'(bus.mem_t), 32'd0);

        // Serial shifts, back to back; SRAI with upper immediate bits set
        run_shift("sra", 7'h33, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 4, 32'hF800_0000);
        run_shift("sll", 7'h33, 3'b001, 1'b0, 32'h0000_0001, 32'd3, 3, 32'h0000_0008);
        run_shift("srai", 7'h13, 3'b101, 1'b1, 32'hF000_0000, 32'h0000_0404, 4, 32'hFF00_0000);
        run_shift("srl", 7'h13, 3'b101, 1'b0, 32'hF000_0000, 32'd1, 1, 32'h7800_0000);
        run_shift("sll31", 7'h33, 3'b001, 1'b0, 32'h0000_0003, 32'd31, 31, 32'h8000_0000);

        // Reset in the middle of an SRL by 10
        drive(7'h33, 3'b101, 1'b0, 32'hFFFF_0000, 32'd10, 5'd5, 1'b1);
        step();
        step();
        step();
        check("rstmid_pre_stall", 32'(bus.stall_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_stall", 32'(bus.stall_req), 32'd0);
        check("rstmid_res", bus.mem_res, 32'h0);
        check("rstmid_we", 32'(bus.mem_we), 32'd0);
        step();
        bubble_in();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("rstmid_no_partial", 32'(bus.mem_we), 32'd0);
        end
        run_one("rstmid_next", 7'h33, 3'b000, 1'b0, 32'd100, 32'd23, 32'd123);

        // Flush in the middle of the same SRL
        drive(7'h33, 3'b101, 1'b0, 32'hFFFF_0000, 32'd10, 5'd5, 1'b1);
        step();
        step();
        step();
        bus.flush = 1'b1;
        #1;
        check("flush_stall", 32'(bus.stall_req), 32'd0);
        step();
        bus.flush = 1'b0;
        check("flush_bub_t", 32'(bus.mem_t), 32'd0);
        check("flush_bub_res", bus.mem_res, 32'h0);
        run_one("flush_next", 7'h33, 3'b000, 1'b0, 32'd40, 32'd2, 32'd42);
        run_shift("flush_shift", 7'h33, 3'b101, 1'b0, 32'h0000_0080, 32'd3, 3, 32'h0000_0010);

        // Flush on a plain op in IDLE kills it
        drive(7'h33, 3'b000, 1'b0, 32'd1, 32'd1, 5'd2, 1'b1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_idle_we", 32'(bus.mem_we), 32'd0);
        check("flush_idle_res", bus.mem_res, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
